rr_priority_arbiter: RTL and testbench

RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

---
 rtl/rr_priority_arbiter.sv | 99 +++++++++
 tb/tb_rr_priority_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// LSB/MSB/round-robin arbiter with a registered one-hot grant and binary index, valid one cycle after request.
// A grant is held until ready; when ready, the next winner is registered in the same edge so grants run back-to-back.
module rr_priority_arbiter #(
   parameter int    WIDTH = 8,
   parameter string MODE  = "RR"
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         requests,
   input  logic                     ready,
   output logic [WIDTH-1:0]         grant,
   output logic [$clog2(WIDTH)-1:0] grant_index,
   output logic                     valid
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    ptr, ptr_nxt, ptr_inc;
   logic [IW-1:0]    idx_nxt;
   logic [WIDTH-1:0] grant_nxt;
   logic [WIDTH-1:0] masked;

   // Round-robin rotates the candidates so the pointer lands at bit 0, then maps the offset back.
   function automatic logic [IW-1:0] pick(input logic [WIDTH-1:0] cand, input logic [IW-1:0] start);
      logic [IW-1:0]      win;
      logic [IW-1:0]      off;
      logic [2*WIDTH-1:0] rot;
      logic [IW:0]        sum;
      win = '0;
      off = '0;
      rot = '0;
      sum = '0;
      if (MODE == "LSB") begin
         for (int i = WIDTH-1; i >= 0; i--)
            if (cand[i]) win = IW'(i);
      end else if (MODE == "MSB") begin
         for (int i = 0; i < WIDTH; i++)
            if (cand[i]) win = IW'(i);
      end else begin
         rot = {cand, cand} >> start;
         for (int i = WIDTH-1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
         sum = {1'b0, start} + {1'b0, off};
         if (sum >= (IW+1)'(WIDTH)) sum = sum - (IW+1)'(WIDTH);
         win = sum[IW-1:0];
      end
      return win;
   endfunction

   assign masked  = requests & ~grant;
   assign ptr_inc = (grant_index == IW'(WIDTH-1)) ? '0 : grant_index + IW'(1);

   always_comb begin
      state_nxt = state;
      idx_nxt   = grant_index;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (|requests) begin
               idx_nxt   = pick(requests, ptr);
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (ready) begin
               ptr_nxt = ptr_inc;
               if (|masked) begin
                  idx_nxt = pick(masked, ptr_inc);
               end else begin
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      grant_nxt = (state_nxt == HOLD) ? ({{(WIDTH-1){1'b0}}, 1'b1} << idx_nxt) : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         grant_index <= '0;
         ptr         <= '0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         grant_index <= idx_nxt;
         ptr         <= ptr_nxt;
      end
   end

   assign valid = (state == HOLD);

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Four arbiter configurations (LSB/8, MSB/8, RR/5, RR/8) checked every cycle against a behavioural model.
module tb_rr_priority_arbiter;

   logic        clock;
   logic        rst [4];
   logic        rdy [4];
   logic [63:0] rq  [4];

   logic [7:0] g0, g1, g3;
   logic [4:0] g2;
   logic [2:0] gi0, gi1, gi2, gi3;
   logic       v0, v1, v2, v3;

   int checks = 0;
   int errors = 0;

   int mw [4] = '{8, 8, 5, 8};
   int mm [4] = '{0, 1, 2, 2};   // 0 lowest wins, 1 highest wins, 2 round-robin
   int m_hold [4];
   int m_idx  [4];
   int m_ptr  [4];

   rr_priority_arbiter #(.WIDTH(8), .MODE("LSB")) u_lsb (
      .clock(clock), .reset(rst[0]), .requests(rq[0][7:0]), .ready(rdy[0]),
      .grant(g0), .grant_index(gi0), .valid(v0));
   rr_priority_arbiter #(.WIDTH(8), .MODE("MSB")) u_msb (
      .clock(clock), .reset(rst[1]), .requests(rq[1][7:0]), .ready(rdy[1]),
      .grant(g1), .grant_index(gi1), .valid(v1));
   rr_priority_arbiter #(.WIDTH(5), .MODE("RR")) u_rr5 (
      .clock(clock), .reset(rst[2]), .requests(rq[2][4:0]), .ready(rdy[2]),
      .grant(g2), .grant_index(gi2), .valid(v2));
   rr_priority_arbiter #(.WIDTH(8), .MODE("RR")) u_rr8 (
      .clock(clock), .reset(rst[3]), .requests(rq[3][7:0]), .ready(rdy[3]),
      .grant(g3), .grant_index(gi3), .valid(v3));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] obs_g(int n);
      case (n)
         0: return 64'(g0);
         1: return 64'(g1);
         2: return 64'(g2);
         default: return 64'(g3);
      endcase
   endfunction

   function automatic logic [63:0] obs_gi(int n);
      case (n)
         0: return 64'(gi0);
         1: return 64'(gi1);
         2: return 64'(gi2);
         default: return 64'(gi3);
      endcase
   endfunction

   function automatic logic [63:0] obs_v(int n);
      case (n)
         0: return 64'(v0);
         1: return 64'(v1);
         2: return 64'(v2);
         default: return 64'(v3);
      endcase
   endfunction

   // Winner among set bits of c: first hit scanning up, scanning down, or up from start modulo width.
   function automatic int pick(int n, logic [63:0] c, int start);
      int r = -1;
      int w = mw[n];
      if (mm[n] == 0) begin
         for (int i = 0; i < w; i++) if (r < 0 && c[i]) r = i;
      end else if (mm[n] == 1) begin
         for (int i = w-1; i >= 0; i--) if (r < 0 && c[i]) r = i;
      end else begin
         for (int k = 0; k < w; k++) if (r < 0 && c[(start + k) % w]) r = (start + k) % w;
      end
      return r;
   endfunction

   task automatic model_step(int n);
      logic [63:0] cand;
      if (rst[n]) begin
         m_hold[n] = 0; m_idx[n] = 0; m_ptr[n] = 0;
      end else if (m_hold[n] == 0) begin
         if (rq[n] != 0) begin
            m_idx[n]  = pick(n, rq[n], m_ptr[n]);
            m_hold[n] = 1;
         end
      end else if (rdy[n]) begin
         m_ptr[n] = (m_idx[n] + 1) % mw[n];
         cand = rq[n] & ~(64'd1 << m_idx[n]);
         if (cand != 0) m_idx[n] = pick(n, cand, m_ptr[n]);
         else begin m_hold[n] = 0; m_idx[n] = 0; end
      end
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      for (int n = 0; n < 4; n++) model_step(n);
      #1;
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("u%0d_valid", n), obs_v(n), 64'(m_hold[n]));
         chk($sformatf("u%0d_grant", n), obs_g(n), (m_hold[n] != 0) ? (64'd1 << m_idx[n]) : 64'd0);
         chk($sformatf("u%0d_index", n), obs_gi(n), 64'(m_idx[n]));
      end
   endtask

   int s1_exp [4] = '{1, 3, 5, 6};
   int s3_exp [7] = '{0, 1, 2, 3, 4, 0, 1};
   int cnt    [8];

   initial begin
      for (int n = 0; n < 4; n++) begin
         rst[n] = 1'b1; rdy[n] = 1'b0; rq[n] = '0;
         m_hold[n] = 0; m_idx[n] = 0; m_ptr[n] = 0;
      end
      tick();
      chk("reset_valid", 64'(v3), 64'd0);
      for (int n = 0; n < 4; n++) rst[n] = 1'b0;

      // idle with no requests, ready toggling
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 4; n++) rdy[n] = k[0];
         tick();
         chk("s5_valid", 64'(v3), 64'd0);
         chk("s5_grant", 64'(g3), 64'd0);
         chk("s5_index", 64'(gi3), 64'd0);
      end

      // LSB drain, clearing each bit after it is granted
      rq[0] = 64'h6A; rdy[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("s1_index", 64'(gi0), 64'(s1_exp[k]));
         chk("s1_valid", 64'(v0), 64'd1);
         rq[0][s1_exp[k]] = 1'b0;
      end
      tick();
      chk("s1_done", 64'(v0), 64'd0);

      // MSB held under ready=0, granted requester drops mid-hold
      rq[1] = 64'h81; rdy[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("s2_index", 64'(gi1), 64'd7);
         chk("s2_grant", 64'(g1), 64'h80);
         if (k == 1) rq[1] = 64'h01;
      end
      rdy[1] = 1'b1;
      tick();
      chk("s2_next", 64'(gi1), 64'd0);
      rq[1] = '0;
      tick();
      chk("s2_done", 64'(v1), 64'd0);

      // RR width 5 wraps 4 -> 0
      rq[2] = 64'h1F; rdy[2] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("s3_index", 64'(gi2), 64'(s3_exp[k]));
      end
      rq[2] = '0;
      tick();
      tick();

      // RR pointer at 7 wraps to find bit 1, then 4
      rq[3] = 64'h40; rdy[3] = 1'b1;
      tick();
      chk("s4_first", 64'(gi3), 64'd6);
      rq[3] = '0;
      tick();
      chk("s4_idle", 64'(v3), 64'd0);
      rq[3] = 64'h12;
      tick();
      chk("s4_wrap", 64'(gi3), 64'd1);
      tick();
      chk("s4_next", 64'(gi3), 64'd4);

      // reset during hold on index 5 aborts it and clears the pointer
      rq[3] = 64'h20;
      tick();
      chk("s6_hold", 64'(gi3), 64'd5);
      rdy[3] = 1'b0; rst[3] = 1'b1; rq[3] = 64'hFF;
      tick();
      chk("s6_valid", 64'(v3), 64'd0);
      chk("s6_grant", 64'(g3), 64'd0);
      rst[3] = 1'b0;
      tick();
      chk("s6_first", 64'(gi3), 64'd0);
      rdy[3] = 1'b1;
      tick();
      chk("s6_second", 64'(gi3), 64'd1);

      // randomized traffic with occasional resets
      for (int c = 0; c < 600; c++) begin
         for (int n = 0; n < 4; n++) begin
            rq[n]  = {32'd0, $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom)}
                     & ((64'd1 << mw[n]) - 64'd1);
            rdy[n] = ($urandom_range(0, 3) != 0);
            rst[n] = ($urandom_range(0, 63) == 0);
         end
         tick();
      end

      // fairness: all requesting, 16 consecutive grants on RR/8
      for (int n = 0; n < 4; n++) begin rst[n] = 1'b1; rq[n] = '0; rdy[n] = 1'b0; end
      tick();
      for (int n = 0; n < 4; n++) rst[n] = 1'b0;
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      rq[3] = 64'hFF; rdy[3] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         cnt[gi3]++;
      end
      for (int i = 0; i < 8; i++) chk($sformatf("fair_%0d", i), 64'(cnt[i]), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
